urv_csr_file: RTL and testbench

//  Parametrised CSR unit for the uRV execute stage; successor to the single-scratch CSR decoder.

---
 rtl/urv_csr_file_if.sv | 27 ++
 rtl/urv_csr_file.sv | 155 +++++++++++++++
 tb/tb_urv_csr_file.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/urv_csr_file_if.sv
// Decode-to-execute CSR request and the registered execute-side response.
// The master (decoder) drives d_*; the slave (CSR unit) drives x_*.
interface urv_csr_file_if;
    logic        d_is_csr_i;
    logic [2:0]  d_fun_i;
    logic [11:0] d_csr_sel_i;
    logic [4:0]  d_csr_imm_i;
    logic [31:0] d_rs1_i;
    logic        d_rs1_zero_i;

    logic [31:0] x_rd_o;
    logic        x_valid_o;
    logic        x_illegal_o;
    logic        x_csr_we_o;
    logic [11:0] x_csr_sel_o;
    logic [31:0] x_csr_write_value_o;

    modport master (
        output d_is_csr_i, d_fun_i, d_csr_sel_i, d_csr_imm_i, d_rs1_i, d_rs1_zero_i,
        input  x_rd_o, x_valid_o, x_illegal_o, x_csr_we_o, x_csr_sel_o, x_csr_write_value_o
    );

    modport slave (
        input  d_is_csr_i, d_fun_i, d_csr_sel_i, d_csr_imm_i, d_rs1_i, d_rs1_zero_i,
        output x_rd_o, x_valid_o, x_illegal_o, x_csr_we_o, x_csr_sel_o, x_csr_write_value_o
    );
endinterface

// File: rtl/urv_csr_file.sv
// uRV execute-stage CSR unit: cycle/instret counters, scratch registers,
// CSRRW/S/C (+immediate forms), illegal-access detection, registered results.
module urv_csr_file #(
    parameter int CNT_WIDTH     = 40,
    parameter int N_SCRATCH     = 1,
    parameter int WITH_INSTRET  = 1,
    parameter int USER_COUNTERS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 x_stall_i,
    input  logic                 x_kill_i,
    input  logic                 x_retire_i,
    input  logic [CNT_WIDTH-1:0] csr_time_i,
    input  logic [31:0]          csr_mstatus_i,
    input  logic [31:0]          csr_mip_i,
    input  logic [31:0]          csr_mie_i,
    input  logic [31:0]          csr_mepc_i,
    input  logic [31:0]          csr_mcause_i,
    urv_csr_file_if.slave        bus
);

    logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d;
    logic [CNT_WIDTH-1:0] minstret_q, minstret_d;
    logic [31:0]          scratch_q [N_SCRATCH];
    logic [N_SCRATCH-1:0] scratch_hit;

    logic        x_valid_q, x_illegal_q, x_csr_we_q;
    logic [31:0] x_rd_q, x_csr_write_value_q;
    logic [11:0] x_csr_sel_q;

    logic        issue, known, is_user, op_bad, wr_req, illegal, do_write;
    logic [31:0] old_val, src, wval;
    logic [11:0] sel;

    assign sel    = bus.d_csr_sel_i;
    assign issue  = bus.d_is_csr_i & ~x_stall_i & ~x_kill_i;
    assign src    = bus.d_fun_i[2] ? {27'b0, bus.d_csr_imm_i} : bus.d_rs1_i;
    assign op_bad = (bus.d_fun_i[1:0] == 2'b00);
    assign wr_req = (bus.d_fun_i[1:0] == 2'b01) | ~bus.d_rs1_zero_i;

    // Scratch #0 is mscratch; the rest sit in the custom 0x7C0 window.
    genvar gi;
    generate
        for (gi = 0; gi < N_SCRATCH; gi++) begin : g_scratch_dec
            localparam logic [11:0] ADDR = (gi == 0) ? 12'h340 : 12'(12'h7C0 + gi - 1);
            assign scratch_hit[gi] = (sel == ADDR);
        end
    endgenerate

    always_comb begin
        old_val = '0;
        known   = 1'b0;
        is_user = 1'b0;
        case (sel)
            12'hB00: begin known = 1'b1; old_val = mcycle_q[31:0]; end
            12'hB80: begin known = 1'b1; old_val = 32'(mcycle_q >> 32); end
            12'hB02: begin known = 1'b1; old_val = minstret_q[31:0]; end
            12'hB82: begin known = 1'b1; old_val = 32'(minstret_q >> 32); end
            12'hC00: begin known = 1'b1; is_user = 1'b1; old_val = mcycle_q[31:0]; end
            12'hC80: begin known = 1'b1; is_user = 1'b1; old_val = 32'(mcycle_q >> 32); end
            12'hC01: begin known = 1'b1; is_user = 1'b1; old_val = csr_time_i[31:0]; end
            12'hC81: begin known = 1'b1; is_user = 1'b1; old_val = 32'(csr_time_i >> 32); end
            12'hC02: begin known = 1'b1; is_user = 1'b1; old_val = minstret_q[31:0]; end
            12'hC82: begin known = 1'b1; is_user = 1'b1; old_val = 32'(minstret_q >> 32); end
            12'h300: begin known = 1'b1; old_val = csr_mstatus_i; end
            12'h304: begin known = 1'b1; old_val = csr_mie_i; end
            12'h341: begin known = 1'b1; old_val = csr_mepc_i; end
            12'h342: begin known = 1'b1; old_val = csr_mcause_i; end
            12'h344: begin known = 1'b1; old_val = csr_mip_i; end
            default: ;
        endcase
        for (int k = 0; k < N_SCRATCH; k++) begin
            if (scratch_hit[k]) begin
                known   = 1'b1;
                old_val = scratch_q[k];
            end
        end
    end

    assign illegal  = op_bad | ~known | (is_user & wr_req) | (is_user & (USER_COUNTERS == 0));
    assign do_write = issue & ~illegal & wr_req;

    always_comb begin
        case (bus.d_fun_i[1:0])
            2'b10:   wval = old_val | src;
            2'b11:   wval = old_val & ~src;
            default: wval = src;
        endcase
    end

    // A write to either half replaces that counter's increment for the cycle.
    always_comb begin
        mcycle_d = mcycle_q + CNT_WIDTH'(1);
        if (do_write && sel == 12'hB00)
            mcycle_d = {mcycle_q[CNT_WIDTH-1:32], wval};
        else if (do_write && sel == 12'hB80)
            mcycle_d = {wval[CNT_WIDTH-33:0], mcycle_q[31:0]};
    end

    generate
        if (WITH_INSTRET != 0) begin : g_instret
            always_comb begin
                minstret_d = minstret_q + (x_retire_i ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
                if (do_write && sel == 12'hB02)
                    minstret_d = {minstret_q[CNT_WIDTH-1:32], wval};
                else if (do_write && sel == 12'hB82)
                    minstret_d = {wval[CNT_WIDTH-33:0], minstret_q[31:0]};
            end
        end else begin : g_no_instret
            assign minstret_d = '0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            for (int k = 0; k < N_SCRATCH; k++) scratch_q[k] <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            for (int k = 0; k < N_SCRATCH; k++)
                if (do_write && scratch_hit[k]) scratch_q[k] <= wval;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            x_valid_q           <= 1'b0;
            x_illegal_q         <= 1'b0;
            x_csr_we_q          <= 1'b0;
            x_rd_q              <= '0;
            x_csr_sel_q         <= '0;
            x_csr_write_value_q <= '0;
        end else begin
            x_valid_q   <= issue;
            x_illegal_q <= issue & illegal;
            x_csr_we_q  <= do_write;
            if (issue) begin
                x_rd_q              <= illegal ? 32'd0 : old_val;
                x_csr_sel_q         <= sel;
                x_csr_write_value_q <= wval;
            end
        end
    end

    assign bus.x_valid_o           = x_valid_q;
    assign bus.x_illegal_o         = x_illegal_q;
    assign bus.x_csr_we_o          = x_csr_we_q;
    assign bus.x_rd_o              = x_rd_q;
    assign bus.x_csr_sel_o         = x_csr_sel_q;
    assign bus.x_csr_write_value_o = x_csr_write_value_q;

endmodule

// File: tb/tb_urv_csr_file.sv
// Randomised + directed bench for urv_csr_file against a behavioural CSR model.
module tb_urv_csr_file;
    localparam int CNT_W = 40;
    localparam int N_SCR = 3;
    localparam longint unsigned CMASK = (64'd1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall = 1'b0, kill = 1'b0, retire = 1'b0;
    logic [CNT_W-1:0]  time_v = '0;
    logic [31:0]       mstatus = '0, mip = '0, mie = '0, mepc = '0, mcause = '0;

    urv_csr_file_if bus ();

    urv_csr_file #(.CNT_WIDTH(CNT_W), .N_SCRATCH(N_SCR), .WITH_INSTRET(1), .USER_COUNTERS(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(stall), .x_kill_i(kill), .x_retire_i(retire),
        .csr_time_i(time_v), .csr_mstatus_i(mstatus), .csr_mip_i(mip), .csr_mie_i(mie),
        .csr_mepc_i(mepc), .csr_mcause_i(mcause), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // model state
    longint unsigned cyc_m, ins_m;
    logic [31:0] scr_m [N_SCR];
    logic [31:0] exp_rd, exp_wv;
    logic [11:0] exp_sel;
    bit          exp_valid, exp_we, exp_ill, exp_wv_chk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int scratch_idx(input logic [11:0] a);
        if (a == 12'h340) return 0;
        if (a >= 12'h7C0 && int'(a) < 'h7C0 + N_SCR - 1) return int'(a) - 'h7C0 + 1;
        return -1;
    endfunction

    function automatic void model_read(input logic [11:0] a, output bit known, output bit user,
                                       output logic [31:0] v);
        longint unsigned t = 64'(time_v);
        known = 1; user = 0; v = '0;
        case (a)
            12'hB00: v = 32'(cyc_m);
            12'hB80: v = 32'(cyc_m >> 32);
            12'hB02: v = 32'(ins_m);
            12'hB82: v = 32'(ins_m >> 32);
            12'hC00: begin user = 1; v = 32'(cyc_m); end
            12'hC80: begin user = 1; v = 32'(cyc_m >> 32); end
            12'hC01: begin user = 1; v = 32'(t); end
            12'hC81: begin user = 1; v = 32'(t >> 32); end
            12'hC02: begin user = 1; v = 32'(ins_m); end
            12'hC82: begin user = 1; v = 32'(ins_m >> 32); end
            12'h300: v = mstatus;
            12'h304: v = mie;
            12'h341: v = mepc;
            12'h342: v = mcause;
            12'h344: v = mip;
            default: begin
                if (scratch_idx(a) >= 0) v = scr_m[scratch_idx(a)];
                else known = 0;
            end
        endcase
    endfunction

    // One clock: predict from pre-edge state, advance model at the edge, check 1 time unit later.
    task automatic step();
        bit issue, known, user, ill, wr, cyc_wr, ins_wr;
        logic [31:0] old, src, wval;
        logic [11:0] a;
        logic [2:0]  f;
        longint unsigned w64;
        a = bus.d_csr_sel_i;
        f = bus.d_fun_i;
        issue = bus.d_is_csr_i && !stall && !kill;
        model_read(a, known, user, old);
        src  = f[2] ? {27'b0, bus.d_csr_imm_i} : bus.d_rs1_i;
        wr   = (f[1:0] == 2'b01) || !bus.d_rs1_zero_i;
        ill  = (f[1:0] == 2'b00) || !known || (user && wr);
        wval = (f[1:0] == 2'b10) ? (old | src) : (f[1:0] == 2'b11) ? (old & ~src) : src;
        @(posedge clk);
        cyc_wr = 0; ins_wr = 0;
        w64 = 64'(wval);
        if (issue && !ill && wr) begin
            case (a)
                12'hB00: begin cyc_wr = 1; cyc_m = (cyc_m & ~64'hFFFF_FFFF) | w64; end
                12'hB80: begin cyc_wr = 1; cyc_m = ((cyc_m & 64'hFFFF_FFFF) | (w64 << 32)) & CMASK; end
                12'hB02: begin ins_wr = 1; ins_m = (ins_m & ~64'hFFFF_FFFF) | w64; end
                12'hB82: begin ins_wr = 1; ins_m = ((ins_m & 64'hFFFF_FFFF) | (w64 << 32)) & CMASK; end
                default: if (scratch_idx(a) >= 0) scr_m[scratch_idx(a)] = wval;
            endcase
        end
        if (!cyc_wr) cyc_m = (cyc_m + 1) & CMASK;
        if (!ins_wr && retire) ins_m = (ins_m + 1) & CMASK;
        exp_valid = issue;
        exp_ill   = issue && ill;
        exp_we    = issue && !ill && wr;
        if (issue) begin
            exp_rd = ill ? 32'd0 : old;
            exp_sel = a;
            exp_wv = wval;
            exp_wv_chk = !ill;
        end
        #1;
        check_value("valid", bus.x_valid_o, exp_valid);
        check_value("illegal", bus.x_illegal_o, exp_ill);
        check_value("csr_we", bus.x_csr_we_o, exp_we);
        check_value("rd", bus.x_rd_o, exp_rd);
        check_value("sel", bus.x_csr_sel_o, exp_sel);
        if (exp_wv_chk) check_value("write_value", bus.x_csr_write_value_o, exp_wv);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_value({tag, "_valid"}, bus.x_valid_o, 0);
        check_value({tag, "_illegal"}, bus.x_illegal_o, 0);
        check_value({tag, "_we"}, bus.x_csr_we_o, 0);
        check_value({tag, "_rd"}, bus.x_rd_o, 0);
        check_value({tag, "_sel"}, bus.x_csr_sel_o, 0);
        check_value({tag, "_wv"}, bus.x_csr_write_value_o, 0);
    endtask

    task automatic do_reset(input bit check_now);
        bus.d_is_csr_i = 0;
        rst_n = 0;
        #1;
        if (check_now) check_outputs_zero("rst_async");
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("rst_hold");
        cyc_m = 0; ins_m = 0;
        for (int k = 0; k < N_SCR; k++) scr_m[k] = '0;
        exp_rd = '0; exp_wv = '0; exp_sel = '0;
        exp_valid = 0; exp_we = 0; exp_ill = 0; exp_wv_chk = 1;
        rst_n = 1;
    endtask

    task automatic csr_op(input logic [2:0] f, input logic [11:0] a, input logic [31:0] rs1,
                          input logic [4:0] imm, input bit zero);
        bus.d_is_csr_i = 1; bus.d_fun_i = f; bus.d_csr_sel_i = a;
        bus.d_rs1_i = rs1; bus.d_csr_imm_i = imm; bus.d_rs1_zero_i = zero;
        step();
        bus.d_is_csr_i = 0;
    endtask

    logic [11:0] addr_tab [21] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC01, 12'hC02,
                                   12'hC80, 12'hC81, 12'hC82, 12'h300, 12'h304, 12'h341, 12'h342,
                                   12'h344, 12'h340, 12'h7C0, 12'h7C1, 12'h7C2, 12'hC83, 12'h000};

    initial begin
        bus.d_is_csr_i = 0; bus.d_fun_i = 0; bus.d_csr_sel_i = 0;
        bus.d_csr_imm_i = 0; bus.d_rs1_i = 0; bus.d_rs1_zero_i = 0;
        do_reset(0);

        repeat (10) step();
        csr_op(3'b010, 12'hB00, 0, 0, 1);
        check_value("mcycle_after_idle", bus.x_rd_o, 32'd10);

        csr_op(3'b001, 12'h340, 32'hDEADBEEF, 0, 0);
        csr_op(3'b011, 12'h340, 32'h0000FFFF, 0, 0);
        check_value("mscratch_rc_old", bus.x_rd_o, 32'hDEADBEEF);
        csr_op(3'b010, 12'h340, 0, 0, 1);
        check_value("mscratch_after_rc", bus.x_rd_o, 32'hDEAD0000);

        csr_op(3'b001, 12'hB80, 32'hFF, 0, 0);
        csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF, 0, 0);
        step();
        csr_op(3'b010, 12'hB80, 0, 0, 1);
        check_value("mcycle_hi_wrap", bus.x_rd_o, 32'd0);
        csr_op(3'b010, 12'hB00, 0, 0, 1);
        check_value("mcycle_lo_small", bus.x_rd_o < 32'd16, 1);

        csr_op(3'b001, 12'hC00, 32'd5, 0, 0);
        check_value("cycle_write_illegal", bus.x_illegal_o, 1);
        check_value("cycle_write_no_we", bus.x_csr_we_o, 0);
        csr_op(3'b010, 12'hC00, 0, 0, 1);
        check_value("cycle_read_legal", bus.x_illegal_o, 0);

        kill = 1;
        csr_op(3'b001, 12'h340, 32'h12345678, 0, 0);
        kill = 0;
        check_value("kill_no_valid", bus.x_valid_o, 0);
        csr_op(3'b010, 12'h340, 0, 0, 1);
        check_value("kill_mscratch_kept", bus.x_rd_o, 32'hDEAD0000);

        retire = 1;
        csr_op(3'b001, 12'hB02, 32'd100, 0, 0);
        retire = 0;
        csr_op(3'b010, 12'hB02, 0, 0, 1);
        check_value("minstret_write_wins", bus.x_rd_o, 32'd100);

        csr_op(3'b001, 12'h7C1, 32'h55, 0, 0);
        csr_op(3'b010, 12'h7C1, 0, 0, 1);
        check_value("scratch2_readback", bus.x_rd_o, 32'h55);
        csr_op(3'b001, 12'h7C2, 32'h1, 0, 0);
        check_value("scratch_oob_illegal", bus.x_illegal_o, 1);
        csr_op(3'b001, 12'h7C0, 32'h1234, 0, 0);
        csr_op(3'b010, 12'h340, 0, 0, 1);
        check_value("mscratch_independent", bus.x_rd_o, 32'hDEAD0000);
        csr_op(3'b110, 12'h7C1, 32'hFFFF_FFFF, 5'h0A, 0);
        csr_op(3'b010, 12'h7C1, 0, 0, 1);
        check_value("rsi_imm_operand", bus.x_rd_o, 32'h5F);

        csr_op(3'b001, 12'h340, 32'hCAFE, 0, 0);
        do_reset(1);
        csr_op(3'b010, 12'h340, 0, 0, 1);
        check_value("mscratch_after_reset", bus.x_rd_o, 32'd0);

        for (int i = 0; i < 400; i++) begin
            bus.d_is_csr_i   = ($urandom_range(0, 9) < 7);
            bus.d_fun_i      = 3'($urandom_range(0, 7));
            bus.d_csr_sel_i  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 20)];
            bus.d_rs1_i      = $urandom;
            bus.d_csr_imm_i  = 5'($urandom);
            bus.d_rs1_zero_i = ($urandom_range(0, 3) == 0);
            stall   = ($urandom_range(0, 6) == 0);
            kill    = ($urandom_range(0, 6) == 0);
            retire  = $urandom_range(0, 1) == 1;
            time_v  = CNT_W'({$urandom, $urandom});
            mstatus = $urandom; mip = $urandom; mie = $urandom; mepc = $urandom; mcause = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
